// File: rtl/game_phase_ctrl.sv
// Game phase sequencer: IDLE/READY/PLAY/DEATH/CLEAR/OVER with a frame-tick
// phase timer, lives and level bookkeeping, and respawn/level-up pulses.
module game_phase_ctrl #(
   parameter int unsigned LIVES_INIT  = 3,
   parameter int unsigned READY_TICKS = 120,
   parameter int unsigned DEATH_TICKS = 90,
   parameter int unsigned CLEAR_TICKS = 120
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       start,
   input  logic       left,
   input  logic       right,
   input  logic       pacman_hit,
   input  logic       dots_clear,
   output logic       pause,
   output logic       restart_pacman,
   output logic       loose_game,
   output logic       level_up,
   output logic [1:0] lives,
   output logic [3:0] level,
   output logic [2:0] phase
);

   localparam int unsigned TIMER_W = 8;
   localparam logic [TIMER_W-1:0] TIMER_MAX = {TIMER_W{1'b1}};
   localparam logic [TIMER_W-1:0] READY_T   = TIMER_W'(READY_TICKS);
   localparam logic [TIMER_W-1:0] DEATH_T   = TIMER_W'(DEATH_TICKS);
   localparam logic [TIMER_W-1:0] CLEAR_T   = TIMER_W'(CLEAR_TICKS);
   localparam logic [1:0]         LIVES_I   = 2'(LIVES_INIT);
   localparam logic [3:0]         LEVEL_MAX = 4'd15;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READY = 3'd1,
      S_PLAY  = 3'd2,
      S_DEATH = 3'd3,
      S_CLEAR = 3'd4,
      S_OVER  = 3'd5
   } state_t;

   state_t             r_state;
   logic [TIMER_W-1:0] r_timer;
   logic               r_pause;
   logic               r_restart;
   logic               r_loose;
   logic               r_level_up;
   logic [1:0]         r_lives;
   logic [3:0]         r_level;

   logic [TIMER_W-1:0] w_timer_inc;
   logic               w_dir;

   // Saturating tick count; a transition overrides it back to zero.
   assign w_timer_inc = (tick && (r_timer != TIMER_MAX)) ? r_timer + TIMER_W'(1) : r_timer;
   assign w_dir       = left | right;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_timer    <= '0;
         r_pause    <= 1'b1;
         r_restart  <= 1'b0;
         r_loose    <= 1'b0;
         r_level_up <= 1'b0;
         r_lives    <= '0;
         r_level    <= '0;
      end else begin
         r_timer    <= w_timer_inc;
         r_restart  <= 1'b0;
         r_level_up <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state   <= S_READY;
                  r_timer   <= '0;
                  r_lives   <= LIVES_I;
                  r_level   <= '0;
                  r_restart <= 1'b1;
               end
            end
            S_READY: begin
               if ((r_timer == READY_T) || (w_dir && (r_timer != '0))) begin
                  r_state <= S_PLAY;
                  r_timer <= '0;
                  r_pause <= 1'b0;
               end
            end
            S_PLAY: begin
               // A simultaneous clear beats a collision and spares the life.
               if (dots_clear) begin
                  r_state <= S_CLEAR;
                  r_timer <= '0;
                  r_pause <= 1'b1;
               end else if (pacman_hit) begin
                  r_state <= S_DEATH;
                  r_timer <= '0;
                  r_pause <= 1'b1;
                  if (r_lives != '0) r_lives <= r_lives - 2'd1;
               end
            end
            S_DEATH: begin
               if (r_timer == DEATH_T) begin
                  r_timer <= '0;
                  if (r_lives == '0) begin
                     r_state <= S_OVER;
                     r_loose <= 1'b1;
                  end else begin
                     r_state   <= S_READY;
                     r_restart <= 1'b1;
                  end
               end
            end
            S_CLEAR: begin
               if (r_timer == CLEAR_T) begin
                  r_state    <= S_READY;
                  r_timer    <= '0;
                  r_level    <= (r_level == LEVEL_MAX) ? LEVEL_MAX : r_level + 4'd1;
                  r_level_up <= 1'b1;
                  r_restart  <= 1'b1;
               end
            end
            S_OVER: begin
               if (start) begin
                  r_state   <= S_READY;
                  r_timer   <= '0;
                  r_lives   <= LIVES_I;
                  r_level   <= '0;
                  r_loose   <= 1'b0;
                  r_restart <= 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_timer <= '0;
               r_pause <= 1'b1;
               r_loose <= 1'b0;
            end
         endcase
      end
   end

   assign pause          = r_pause;
   assign restart_pacman = r_restart;
   assign loose_game     = r_loose;
   assign level_up       = r_level_up;
   assign lives          = r_lives;
   assign level          = r_level;
   assign phase          = r_state;

endmodule

// File: tb/tb_game_phase_ctrl.sv
// Bench for game_phase_ctrl: directed scenarios then random play, every cycle
// compared against a rule-level reference model of the game phases.
module tb_game_phase_ctrl;

   localparam int LI = 3, RT = 3, DT = 2, CT = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1, tick = 1'b0, start = 1'b0, left = 1'b0, right = 1'b0;
   logic       pacman_hit = 1'b0, dots_clear = 1'b0;
   logic       pause, restart_pacman, loose_game, level_up;
   logic [1:0] lives;
   logic [3:0] level;
   logic [2:0] phase;

   int checks = 0;
   int failures = 0;

   // Reference model state, plain integers.
   int  m_ph = 0, m_t = 0, m_lives = 0, m_level = 0;
   bit  m_restart = 0, m_lvup = 0;

   game_phase_ctrl #(
      .LIVES_INIT(LI), .READY_TICKS(RT), .DEATH_TICKS(DT), .CLEAR_TICKS(CT)
   ) dut (
      .clk(clk), .reset(reset), .tick(tick), .start(start), .left(left), .right(right),
      .pacman_hit(pacman_hit), .dots_clear(dots_clear), .pause(pause),
      .restart_pacman(restart_pacman), .loose_game(loose_game), .level_up(level_up),
      .lives(lives), .level(level), .phase(phase)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Advance the model one clock using the inputs currently applied.
   task automatic model_step();
      int prev = m_ph;
      int nt = (tick && m_t < 255) ? m_t + 1 : m_t;
      if (reset) begin
         m_ph = 0; m_t = 0; m_lives = 0; m_level = 0;
         m_restart = 0; m_lvup = 0;
         return;
      end
      case (m_ph)
         0: if (start) begin m_ph = 1; m_lives = LI; m_level = 0; end
         1: if (m_t == RT || ((left || right) && m_t >= 1)) m_ph = 2;
         2: if (dots_clear) m_ph = 4;
            else if (pacman_hit) begin m_ph = 3; if (m_lives > 0) m_lives--; end
         3: if (m_t == DT) m_ph = (m_lives == 0) ? 5 : 1;
         4: if (m_t == CT) begin m_ph = 1; if (m_level < 15) m_level++; end
         5: if (start) begin m_ph = 1; m_lives = LI; m_level = 0; end
         default: m_ph = 0;
      endcase
      m_t = (m_ph != prev) ? 0 : nt;
      m_restart = (m_ph == 1 && prev != 1);
      m_lvup = (m_ph == 1 && prev == 4);
   endtask

   task automatic check_all();
      chk("phase", 8'(phase), 8'(m_ph));
      chk("lives", 8'(lives), 8'(m_lives));
      chk("level", 8'(level), 8'(m_level));
      chk("pause", 8'(pause), 8'(m_ph != 2));
      chk("loose_game", 8'(loose_game), 8'(m_ph == 5));
      chk("restart_pacman", 8'(restart_pacman), 8'(m_restart));
      chk("level_up", 8'(level_up), 8'(m_lvup));
   endtask

   // One clock with the given inputs; outputs checked 1 time unit after the edge.
   task automatic cyc(input bit rs, input bit t, input bit s, input bit l, input bit r,
                      input bit h, input bit d);
      reset = rs; tick = t; start = s; left = l; right = r; pacman_hit = h; dots_clear = d;
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic idle();      cyc(0, 0, 0, 0, 0, 0, 0); endtask
   task automatic tk();        cyc(0, 1, 0, 0, 0, 0, 0); endtask
   task automatic go_right();  cyc(0, 0, 0, 0, 1, 0, 0); endtask

   initial begin
      // Reset state
      cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(1, 1, 1, 1, 1, 1, 1);
      chk("scn_reset_phase", 8'(phase), 8'd0);
      chk("scn_reset_pause", 8'(pause), 8'd1);

      // Start -> READY, three ticks -> PLAY
      cyc(0, 0, 1, 0, 0, 0, 0);
      chk("scn_start_phase", 8'(phase), 8'd1);
      chk("scn_start_lives", 8'(lives), 8'd3);
      chk("scn_start_restart", 8'(restart_pacman), 8'd1);
      idle();
      chk("scn_restart_one_cycle", 8'(restart_pacman), 8'd0);
      tk(); tk(); tk();
      chk("scn_ready_before_timeout", 8'(phase), 8'd1);
      idle();
      chk("scn_ready_timeout_play", 8'(phase), 8'd2);
      chk("scn_play_pause", 8'(pause), 8'd0);

      // Three deaths -> OVER, start held in PLAY ignored
      for (int k = 0; k < 3; k++) begin
         cyc(0, 0, 1, 0, 0, 0, 0);
         cyc(0, 0, 1, 0, 0, 1, 0);
         chk("scn_death_lives", 8'(lives), 8'(2 - k));
         tk(); tk(); idle();
         if (k < 2) begin
            chk("scn_death_ready", 8'(phase), 8'd1);
            tk(); go_right();
         end
      end
      chk("scn_over_phase", 8'(phase), 8'd5);
      chk("scn_over_loose", 8'(loose_game), 8'd1);
      cyc(0, 0, 1, 0, 0, 0, 0);
      chk("scn_over_restart_phase", 8'(phase), 8'd1);
      chk("scn_over_restart_lives", 8'(lives), 8'd3);
      chk("scn_over_restart_loose", 8'(loose_game), 8'd0);

      // Direction with timer=0 does not leave READY; after one tick it does
      go_right();
      chk("scn_dir_timer0", 8'(phase), 8'd1);
      tk();
      go_right();
      chk("scn_dir_early_play", 8'(phase), 8'd2);

      // Clear and hit together: CLEAR wins, life kept
      cyc(0, 0, 0, 0, 0, 1, 1);
      chk("scn_clear_wins", 8'(phase), 8'd4);
      chk("scn_clear_lives", 8'(lives), 8'd3);
      tk(); tk(); idle();
      chk("scn_clear_level", 8'(level), 8'd1);
      chk("scn_clear_level_up", 8'(level_up), 8'd1);
      idle();
      chk("scn_level_up_one_cycle", 8'(level_up), 8'd0);

      // Level saturates at 15
      for (int k = 0; k < 15; k++) begin
         tk(); go_right();
         cyc(0, 0, 0, 0, 0, 0, 1);
         tk(); tk(); idle();
      end
      chk("scn_level_sat", 8'(level), 8'd15);

      // Reset mid-DEATH countdown
      tk(); go_right();
      cyc(0, 0, 0, 0, 0, 1, 0);
      tk();
      chk("scn_in_death", 8'(phase), 8'd3);
      cyc(1, 1, 1, 0, 0, 0, 0);
      chk("scn_rst_death_phase", 8'(phase), 8'd0);
      chk("scn_rst_death_lives", 8'(lives), 8'd0);
      chk("scn_rst_death_restart", 8'(restart_pacman), 8'd0);

      // Random play against the model
      for (int n = 0; n < 3000; n++) begin
         cyc(($urandom_range(0, 249) == 0),
             ($urandom_range(0, 1) == 0),
             ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 19) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
